// File: rtl/alu_pkg.sv
// Shared widths, ALU opcode encodings and the EX-stage register bundle
// for the ALU issue/writeback stage.
package alu_pkg;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 6;
    localparam int OP_W   = 4;

    localparam logic [OP_W-1:0] OP_OR  = 4'h0;
    localparam logic [OP_W-1:0] OP_XOR = 4'h1;
    localparam logic [OP_W-1:0] OP_AND = 4'h2;
    localparam logic [OP_W-1:0] OP_ADD = 4'h4;
    localparam logic [OP_W-1:0] OP_SUB = 4'h5;
    localparam logic [OP_W-1:0] OP_MUL = 4'h6;
    localparam logic [OP_W-1:0] OP_SHL = 4'h8;
    localparam logic [OP_W-1:0] OP_SAR = 4'h9;
    localparam logic [OP_W-1:0] OP_DIV = 4'hA;
    localparam logic [OP_W-1:0] OP_MOD = 4'hB;

    typedef struct packed {
        logic              valid;
        logic [OP_W-1:0]   op;
        logic [ADDR_W-1:0] dst;
        logic [DATA_W-1:0] d0;
        logic [DATA_W-1:0] d1;
    } ex_reg_t;

endpackage

// File: rtl/alu_regfile.sv
// Integer register file: async active-low clear, one write port,
// three combinational read ports; R0 reads as zero and ignores writes.
module alu_regfile
    import alu_pkg::*;
#(
    parameter int DW = DATA_W,
    parameter int AW = ADDR_W
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic [AW-1:0] raddr0,
    input  logic [AW-1:0] raddr1,
    input  logic [AW-1:0] raddr2,
    output logic [DW-1:0] rdata0,
    output logic [DW-1:0] rdata1,
    output logic [DW-1:0] rdata2
);

    localparam int DEPTH = 1 << AW;

    logic [DEPTH-1:0][DW-1:0] mem_q, mem_d;

    always_comb begin
        mem_d = mem_q;
        if (we && (waddr != '0)) begin
            mem_d[waddr] = wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_q <= '0;
        end else begin
            mem_q <= mem_d;
        end
    end

    assign rdata0 = (raddr0 == '0) ? '0 : mem_q[raddr0];
    assign rdata1 = (raddr1 == '0) ? '0 : mem_q[raddr1];
    assign rdata2 = (raddr2 == '0) ? '0 : mem_q[raddr2];

endmodule

// File: rtl/alu_issue_stage.sv
// Operand fetch / writeback stage wrapped around a combinational ALU.
// Build option ALU_FWD_EN: forward alu_dout on RAW hazards instead of stalling.
module alu_issue_stage
    import alu_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [OP_W-1:0]   in_op,
    input  logic [ADDR_W-1:0] in_dst,
    input  logic [ADDR_W-1:0] in_src0,
    input  logic [ADDR_W-1:0] in_src1,
    output logic [DATA_W-1:0] alu_d0,
    output logic [DATA_W-1:0] alu_d1,
    output logic [OP_W-1:0]   alu_op,
    input  logic [DATA_W-1:0] alu_dout,
    input  logic              ld_valid,
    output logic              ld_ready,
    input  logic [ADDR_W-1:0] ld_dst,
    input  logic [DATA_W-1:0] ld_data,
    output logic              wb_valid,
    output logic [ADDR_W-1:0] wb_dst,
    output logic [DATA_W-1:0] wb_data,
    input  logic [ADDR_W-1:0] dbg_addr,
    output logic [DATA_W-1:0] dbg_data
);

    ex_reg_t           ex_q, ex_d;
    logic              wb_valid_q, wb_valid_d;
    logic [ADDR_W-1:0] wb_dst_q, wb_dst_d;
    logic [DATA_W-1:0] wb_data_q, wb_data_d;

    logic              ld_fire, issue;
    logic              hazard0, hazard1;
    logic [DATA_W-1:0] rf_src0, rf_src1;
    logic [DATA_W-1:0] opnd0, opnd1;
    logic              rf_we;
    logic [ADDR_W-1:0] rf_waddr;
    logic [DATA_W-1:0] rf_wdata;

    // The single write port belongs to the EX writeback whenever one is pending.
    assign ld_ready = !ex_q.valid;
    assign ld_fire  = ld_valid && ld_ready;

    assign hazard0 = ex_q.valid && (ex_q.dst != '0) && (in_src0 == ex_q.dst);
    assign hazard1 = ex_q.valid && (ex_q.dst != '0) && (in_src1 == ex_q.dst);

`ifdef ALU_FWD_EN
    assign in_ready = !ld_fire;
    assign opnd0    = hazard0 ? alu_dout : rf_src0;
    assign opnd1    = hazard1 ? alu_dout : rf_src1;
`else
    // One bubble lets the pending writeback land before the operand read.
    assign in_ready = !ld_fire && !(hazard0 || hazard1);
    assign opnd0    = rf_src0;
    assign opnd1    = rf_src1;
`endif

    assign issue = in_valid && in_ready;

    always_comb begin
        ex_d       = ex_q;
        ex_d.valid = issue;
        if (issue) begin
            ex_d.op  = in_op;
            ex_d.dst = in_dst;
            ex_d.d0  = opnd0;
            ex_d.d1  = opnd1;
        end
    end

    always_comb begin
        wb_valid_d = 1'b0;
        wb_dst_d   = wb_dst_q;
        wb_data_d  = wb_data_q;
        if (ex_q.valid) begin
            wb_valid_d = 1'b1;
            wb_dst_d   = ex_q.dst;
            wb_data_d  = alu_dout;
        end
    end

    always_comb begin
        rf_we    = 1'b0;
        rf_waddr = '0;
        rf_wdata = '0;
        if (ex_q.valid) begin
            rf_we    = 1'b1;
            rf_waddr = ex_q.dst;
            rf_wdata = alu_dout;
        end else if (ld_fire) begin
            rf_we    = 1'b1;
            rf_waddr = ld_dst;
            rf_wdata = ld_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_q       <= '0;
            wb_valid_q <= 1'b0;
            wb_dst_q   <= '0;
            wb_data_q  <= '0;
        end else begin
            ex_q       <= ex_d;
            wb_valid_q <= wb_valid_d;
            wb_dst_q   <= wb_dst_d;
            wb_data_q  <= wb_data_d;
        end
    end

    alu_regfile #(.DW(DATA_W), .AW(ADDR_W)) u_rf (
        .clk    (clk),
        .rst_n  (rst_n),
        .we     (rf_we),
        .waddr  (rf_waddr),
        .wdata  (rf_wdata),
        .raddr0 (in_src0),
        .raddr1 (in_src1),
        .raddr2 (dbg_addr),
        .rdata0 (rf_src0),
        .rdata1 (rf_src1),
        .rdata2 (dbg_data)
    );

    assign alu_d0   = ex_q.d0;
    assign alu_d1   = ex_q.d1;
    assign alu_op   = ex_q.op;
    assign wb_valid = wb_valid_q;
    assign wb_dst   = wb_dst_q;
    assign wb_data  = wb_data_q;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Directed bench for alu_issue_stage: a per-cycle vector table plus hand-written
// hazard, streaming and mid-flight reset sequences against a behavioural ALU.
module tb_alu_issue_stage;

    localparam logic [3:0] ADD = 4'h4, SUB = 4'h5, XOR = 4'h1, SHL = 4'h8;
`ifdef ALU_FWD_EN
    localparam int EXP_STALLS = 0;
`else
    localparam int EXP_STALLS = 1;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, in_ready;
    logic [3:0]  in_op;
    logic [5:0]  in_dst, in_src0, in_src1;
    logic [31:0] alu_d0, alu_d1, alu_dout;
    logic [3:0]  alu_op;
    logic        ld_valid, ld_ready;
    logic [5:0]  ld_dst;
    logic [31:0] ld_data;
    logic        wb_valid;
    logic [5:0]  wb_dst;
    logic [31:0] wb_data;
    logic [5:0]  dbg_addr;
    logic [31:0] dbg_data;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    alu_issue_stage dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
        .in_dst(in_dst), .in_src0(in_src0), .in_src1(in_src1),
        .alu_d0(alu_d0), .alu_d1(alu_d1), .alu_op(alu_op), .alu_dout(alu_dout),
        .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_dst(ld_dst), .ld_data(ld_data),
        .wb_valid(wb_valid), .wb_dst(wb_dst), .wb_data(wb_data),
        .dbg_addr(dbg_addr), .dbg_data(dbg_data)
    );

    function automatic logic [31:0] alu_f(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        case (op)
            4'h0: return a | b;
            4'h1: return a ^ b;
            4'h2: return a & b;
            4'h4: return a + b;
            4'h5: return a - b;
            4'h6: return a * b;
            4'h8: return a << b[4:0];
            4'h9: return $signed(a) >>> b[4:0];
            4'hA: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            4'hB: return (b == 0) ? a : a % b;
            default: return 32'h0;
        endcase
    endfunction

    assign alu_dout = alu_f(alu_op, alu_d0, alu_d1);

    typedef struct {
        logic        iv;
        logic [3:0]  op;
        logic [5:0]  dst, s0, s1;
        logic        lv;
        logic [5:0]  ldst;
        logic [31:0] ldata;
        logic [5:0]  dbg;
        logic        e_ir, e_lr, chk_alu;
        logic [31:0] e_d0, e_d1;
        logic [3:0]  e_op;
        logic        e_wbv;
        logic [5:0]  e_wbdst;
        logic [31:0] e_wbdata, e_dbg;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t V(
        input logic iv, input logic [3:0] op, input logic [5:0] dst, input logic [5:0] s0,
        input logic [5:0] s1, input logic lv, input logic [5:0] ldst, input logic [31:0] ldata,
        input logic [5:0] dbg, input logic e_ir, input logic e_lr, input logic chk_alu,
        input logic [31:0] e_d0, input logic [31:0] e_d1, input logic [3:0] e_op,
        input logic e_wbv, input logic [5:0] e_wbdst, input logic [31:0] e_wbdata,
        input logic [31:0] e_dbg);
        vec_t r;
        r.iv = iv; r.op = op; r.dst = dst; r.s0 = s0; r.s1 = s1;
        r.lv = lv; r.ldst = ldst; r.ldata = ldata; r.dbg = dbg;
        r.e_ir = e_ir; r.e_lr = e_lr; r.chk_alu = chk_alu;
        r.e_d0 = e_d0; r.e_d1 = e_d1; r.e_op = e_op;
        r.e_wbv = e_wbv; r.e_wbdst = e_wbdst; r.e_wbdata = e_wbdata; r.e_dbg = e_dbg;
        return r;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic idle_inputs();
        in_valid = 1'b0; in_op = 4'h0; in_dst = 6'd0; in_src0 = 6'd0; in_src1 = 6'd0;
        ld_valid = 1'b0; ld_dst = 6'd0; ld_data = 32'd0;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected $finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int stalls;
        int accepted;

        // cycle-by-cycle vectors (inputs | in_ready ld_ready | alu check d0 d1 op | wb v dst data | dbg)
        tbl.push_back(V(0,0,0,0,0,    1,1,3,   1, 0,1, 0,0,0,0,      0,0,0,    0));
        tbl.push_back(V(0,0,0,0,0,    1,2,7,   1, 0,1, 0,0,0,0,      0,0,0,    3));
        tbl.push_back(V(1,ADD,3,1,2,  0,0,0,   2, 1,1, 0,0,0,0,      0,0,0,    7));
        tbl.push_back(V(0,0,0,0,0,    0,0,0,   3, 1,0, 1,3,7,ADD,    0,0,0,    0));
        tbl.push_back(V(0,0,0,0,0,    0,0,0,   3, 1,1, 0,0,0,0,      1,3,10,   10));
        tbl.push_back(V(1,ADD,5,1,2,  0,0,0,   3, 1,1, 0,0,0,0,      0,0,0,    10));
        tbl.push_back(V(0,0,0,0,0,    1,6,100, 6, 1,0, 1,3,7,ADD,    0,0,0,    0));
        tbl.push_back(V(1,ADD,7,1,1,  1,6,100, 6, 0,1, 0,0,0,0,      1,5,10,   0));
        tbl.push_back(V(1,ADD,7,1,1,  0,0,0,   6, 1,1, 0,0,0,0,      0,0,0,    100));
        tbl.push_back(V(0,0,0,0,0,    0,0,0,   6, 1,0, 1,3,3,ADD,    0,0,0,    100));
        tbl.push_back(V(0,0,0,0,0,    0,0,0,   7, 1,1, 0,0,0,0,      1,7,6,    6));
        tbl.push_back(V(1,ADD,0,1,2,  0,0,0,   0, 1,1, 0,0,0,0,      0,0,0,    0));
        tbl.push_back(V(1,ADD,8,0,1,  0,0,0,   0, 1,0, 1,3,7,ADD,    0,0,0,    0));
        tbl.push_back(V(0,0,0,0,0,    0,0,0,   0, 1,0, 1,0,3,ADD,    1,0,10,   0));
        tbl.push_back(V(0,0,0,0,0,    0,0,0,   8, 1,1, 0,0,0,0,      1,8,3,    3));
        tbl.push_back(V(1,SUB,9,2,1,  0,0,0,   9, 1,1, 0,0,0,0,      0,0,0,    0));
        tbl.push_back(V(1,XOR,10,1,2, 0,0,0,   9, 1,0, 1,7,3,SUB,    0,0,0,    0));
        tbl.push_back(V(1,SHL,11,2,1, 0,0,0,   9, 1,0, 1,3,7,XOR,    1,9,4,    4));
        tbl.push_back(V(0,0,0,0,0,    0,0,0,   10,1,0, 1,7,3,SHL,    1,10,4,   4));
        tbl.push_back(V(0,0,0,0,0,    0,0,0,   11,1,1, 0,0,0,0,      1,11,56,  56));

        rst_n = 1'b0;
        idle_inputs();
        dbg_addr = 6'd1;
        #3;
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_ld_ready", 32'(ld_ready), 32'd1);
        chk("rst_alu_d0",   alu_d0, 32'd0);
        chk("rst_alu_d1",   alu_d1, 32'd0);
        chk("rst_alu_op",   32'(alu_op), 32'd0);
        chk("rst_wb_valid", 32'(wb_valid), 32'd0);
        chk("rst_wb_dst",   32'(wb_dst), 32'd0);
        chk("rst_wb_data",  wb_data, 32'd0);
        chk("rst_dbg",      dbg_data, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        next_cycle();

        foreach (tbl[i]) begin
            in_valid = tbl[i].iv; in_op = tbl[i].op; in_dst = tbl[i].dst;
            in_src0 = tbl[i].s0; in_src1 = tbl[i].s1;
            ld_valid = tbl[i].lv; ld_dst = tbl[i].ldst; ld_data = tbl[i].ldata;
            dbg_addr = tbl[i].dbg;
            @(negedge clk);
            chk($sformatf("row%0d_in_ready", i), 32'(in_ready), 32'(tbl[i].e_ir));
            chk($sformatf("row%0d_ld_ready", i), 32'(ld_ready), 32'(tbl[i].e_lr));
            if (tbl[i].chk_alu) begin
                chk($sformatf("row%0d_alu_d0", i), alu_d0, tbl[i].e_d0);
                chk($sformatf("row%0d_alu_d1", i), alu_d1, tbl[i].e_d1);
                chk($sformatf("row%0d_alu_op", i), 32'(alu_op), 32'(tbl[i].e_op));
            end
            chk($sformatf("row%0d_wb_valid", i), 32'(wb_valid), 32'(tbl[i].e_wbv));
            if (tbl[i].e_wbv) begin
                chk($sformatf("row%0d_wb_dst", i), 32'(wb_dst), 32'(tbl[i].e_wbdst));
                chk($sformatf("row%0d_wb_data", i), wb_data, tbl[i].e_wbdata);
            end
            chk($sformatf("row%0d_dbg", i), dbg_data, tbl[i].e_dbg);
            next_cycle();
        end
        idle_inputs();

        // RAW hazard: SUB R13 = R12 - R1 straight after ADD R12 = R1 + R2
        in_valid = 1'b1; in_op = ADD; in_dst = 6'd12; in_src0 = 6'd1; in_src1 = 6'd2;
        @(negedge clk);
        chk("hz_first_ready", 32'(in_ready), 32'd1);
        next_cycle();
        in_op = SUB; in_dst = 6'd13; in_src0 = 6'd12; in_src1 = 6'd1;
        stalls = 0;
        accepted = 0;
        for (int k = 0; k < 4 && accepted == 0; k++) begin
            @(negedge clk);
            if (in_ready) accepted = 1;
            else stalls++;
            next_cycle();
        end
        idle_inputs();
        chk("hz_accepted", 32'(accepted), 32'd1);
        chk("hz_stalls", 32'(stalls), 32'(EXP_STALLS));
        @(negedge clk);
        chk("hz_alu_d0", alu_d0, 32'd10);
        chk("hz_alu_d1", alu_d1, 32'd3);
        chk("hz_alu_op", 32'(alu_op), 32'(SUB));
        next_cycle();
        @(negedge clk);
        chk("hz_wb_valid", 32'(wb_valid), 32'd1);
        chk("hz_wb_dst", 32'(wb_dst), 32'd13);
        chk("hz_wb_data", wb_data, 32'd7);
        next_cycle();

        // 8 independent ADDs back to back
        for (int c = 0; c < 10; c++) begin
            in_valid = (c < 8); in_op = ADD; in_dst = 6'(16 + c); in_src0 = 6'd1; in_src1 = 6'd2;
            @(negedge clk);
            if (c < 8) chk($sformatf("st%0d_in_ready", c), 32'(in_ready), 32'd1);
            if (c >= 2) begin
                chk($sformatf("st%0d_wb_valid", c), 32'(wb_valid), 32'd1);
                chk($sformatf("st%0d_wb_dst", c), 32'(wb_dst), 32'(16 + c - 2));
                chk($sformatf("st%0d_wb_data", c), wb_data, 32'd10);
            end
            next_cycle();
        end
        idle_inputs();
        @(negedge clk);
        chk("st_end_wb_valid", 32'(wb_valid), 32'd0);
        next_cycle();

        // reset between accept and writeback
        in_valid = 1'b1; in_op = ADD; in_dst = 6'd24; in_src0 = 6'd1; in_src1 = 6'd2;
        next_cycle();
        idle_inputs();
        #2;
        rst_n = 1'b0;
        #1;
        chk("mr_alu_d0", alu_d0, 32'd0);
        chk("mr_alu_d1", alu_d1, 32'd0);
        chk("mr_alu_op", 32'(alu_op), 32'd0);
        chk("mr_wb_valid", 32'(wb_valid), 32'd0);
        chk("mr_wb_dst", 32'(wb_dst), 32'd0);
        chk("mr_wb_data", wb_data, 32'd0);
        chk("mr_ld_ready", 32'(ld_ready), 32'd1);
        for (int r = 1; r <= 3; r++) begin
            dbg_addr = 6'(r);
            #1;
            chk($sformatf("mr_dbg_r%0d", r), dbg_data, 32'd0);
        end
        next_cycle();
        @(negedge clk);
        rst_n = 1'b1;
        dbg_addr = 6'd24;
        for (int c = 0; c < 3; c++) begin
            next_cycle();
            @(negedge clk);
            chk($sformatf("mr_post%0d_wb_valid", c), 32'(wb_valid), 32'd0);
            chk($sformatf("mr_post%0d_dbg_r24", c), dbg_data, 32'd0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
